mctrl_ws: RTL and testbench
===========================

# mctrl_ws

Parametrised multi-cycle MIPS control unit, successor to the fixed-latency `MCtrl`. It drives the same datapath control outputs and adds four capabilities:
- memory wait-state handling on `MIO_ready`, with an optional timeout;
- an extended instruction set, selectable by parameter;
- optional overflow trapping;
- a sticky error state.

It sits between the instruction register and the multi-cycle datapath of the CPU core.

## Interface
- `WAIT_LIMIT`, 15: maximum consecutive `MIO_ready=0` cycles tolerated in one memory state. 0 disables the timeout.
- `TRAP_ON_OVF`, 1: when 1, add/sub/addi overflow suppresses write-back and pulses `exc_ovf`.
- `ENABLE_EXT`, 1: when 0, the ops bne, jal, jr, lui, andi, ori, xor and nor decode as illegal.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `Inst_in`  in  32  IR contents.
- `zero`, `overflow`  in  1  ALU flags, valid during execute states.
- `MIO_ready`  in  1  memory/IO handshake.
- `MemRead`, `MemWrite`, `CPU_MIO`, `IorD`, `IRWrite`, `RegWrite`, `ALUSrcA`, `PCWrite`, `PCWriteCond`, `Branch`  out  1  datapath controls.
- `RegDst`  out  2  00=rt, 01=rd, 10=$31.
- `MemtoReg`  out  2  00=ALU, 01=MDR, 10=imm<<16, 11=PC.
- `ALUSrcB`  out  2  00=B, 01=4, 10=sign-ext imm, 11=imm<<2.
- `PCSource`  out  2  00=ALU, 01=ALUOut, 10=jump target, 11=reg A.
- `ALU_operation`  out  3  000 and, 001 or, 010 add, 011 xor, 100 nor, 110 sub, 111 slt.
- `state_out`  out  5  current state code.
- `exc_ovf`  out  1  one-cycle overflow-trap pulse.
- `err`  out  1  high while in ERR.

## Operation
- Outputs are decoded from the state register. Any output not listed for a state is 0.
- `CPU_MIO=1` in IF, MEM_RD and MEM_WR.

States (code shown in brackets) and their asserted outputs:
- IF(0): MemRead, ALUSrcB=01, add, PCSource=00. IRWrite and PCWrite are gated by `MIO_ready` (Mealy). Advances to ID only when `MIO_ready=1`.
- ID(1): ALUSrcB=11, add. Dispatches on opcode:
  - 100011/101011 → MA
  - 000000 → RX, or JR if funct=001000
  - 000100/000101 → BR
  - 000010 → J
  - 000011 → JAL
  - 001000/001010/001100/001101 → IX
  - 001111 → LUI
  - anything else → ERR
- MA(2): ALUSrcA=1, ALUSrcB=10, add. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD(3): MemRead, IorD. Advances to LW_WB when `MIO_ready=1`.
- LW_WB(4): RegDst=00, MemtoReg=01, RegWrite → IF.
- MEM_WR(5): MemWrite, IorD. Goes to IF when `MIO_ready=1`.
- RX(6): ALUSrcA=1, ALUSrcB=00, ALU op by funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt.
  - Any other funct → ERR.
  - If overflow on add/sub and TRAP_ON_OVF=1 → IF with `exc_ovf=1` this cycle; otherwise → RX_WB.
- RX_WB(7): RegDst=01, RegWrite → IF.
- BR(8): ALUSrcA=1, ALUSrcB=00, sub, PCSource=01, PCWriteCond. Branch=1 for beq, 0 for bne → IF.
- J(9): PCSource=10, PCWrite → IF.
- IX(10): ALUSrcA=1, ALUSrcB=10, op: addi add, slti slt, andi and, ori or. Overflow on addi follows the same trap rule as RX → IX_WB or IF.
- IX_WB(11): RegDst=00, RegWrite → IF.
- LUI(12): RegDst=00, MemtoReg=10, RegWrite → IF.
- JAL(13): RegDst=10, MemtoReg=11, RegWrite, PCSource=10, PCWrite → IF.
- JR(14): PCSource=11, PCWrite → IF.
- ERR(15): `err=1`, all other outputs 0. Sticky until reset.

Rules:
- With ENABLE_EXT=0, the gated ops decode to ERR from ID. xor/nor go to ERR from RX.
- Wait counter:
  - cleared on entry to IF, MEM_RD or MEM_WR, and on every `MIO_ready=1`;
  - increments on each `MIO_ready=0` cycle in those states;
  - when it reaches WAIT_LIMIT (nonzero) with ready still low, the FSM goes to ERR on the next edge.
  - Width is clog2(WAIT_LIMIT+1), minimum 1.

## Timing
- Reset (`reset=0`, asynchronous): state=IF, counter=0, `exc_ovf=0`, `err=0`.
  - In reset, the IF Moore outputs are visible: MemRead=1, CPU_MIO=1, ALUSrcB=01, ALU_operation=010, state_out=0.
  - IRWrite and PCWrite follow `MIO_ready`.
- Reset asserted mid-instruction, including during a memory wait, aborts to IF immediately. No further RegWrite/MemWrite is issued.
- Latency with zero waits: lw 5, sw 4, R/I-type 4, beq/bne/j/jal/jr/lui 3 cycles. Each wait cycle adds 1.
- When overflow and `MIO_ready` change in the same cycle, they are evaluated only in their own states; there is no interaction.
- `exc_ovf` is combinational in RX/IX and lasts exactly one cycle.

## Test plan
- Reset, then lw `0x8E530000` with `MIO_ready=1` → state_out 0,1,2,3,4,0; RegWrite=1 only in state 4.
- sw `0xAE530000` with `MIO_ready=0` for 3 cycles in MEM_WR → MemWrite held 4 cycles, then IF; no ERR.
- With WAIT_LIMIT=4, hold `MIO_ready=0` in IF → ERR after 5 cycles (err=1, state_out=15); only reset clears it.
- add `0x02538820` with overflow=1 in RX → `exc_ovf` pulses 1 cycle, no RegWrite, next state 0. With TRAP_ON_OVF=0 → RX_WB with RegWrite.
- jal `0x0C000000` → RegDst=10, MemtoReg=11, PCWrite, PCSource=10. jr `0x03E00008` → PCSource=11.
- With ENABLE_EXT=0, lui `0x3C105555` → ERR from ID. bne `0x16720002` → ERR. beq → state 8 with Branch=1.

Source files
------------

// File: rtl/mctrl_ws.sv
// Multi-cycle MIPS control unit with memory wait states, optional timeout,
// extended opcodes, optional overflow trap and a sticky error state.
module mctrl_ws #(
  parameter int WAIT_LIMIT  = 15,
  parameter bit TRAP_ON_OVF = 1'b1,
  parameter bit ENABLE_EXT  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst_in,
  input  logic        zero,
  input  logic        overflow,
  input  logic        MIO_ready,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        CPU_MIO,
  output logic        IorD,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [2:0]  ALU_operation,
  output logic [4:0]  state_out,
  output logic        exc_ovf,
  output logic        err
);

  localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT_CNT = CW'(WAIT_LIMIT);

  typedef enum logic [4:0] {
    S_IF = 5'd0, S_ID = 5'd1, S_MA = 5'd2, S_MEM_RD = 5'd3, S_LW_WB = 5'd4,
    S_MEM_WR = 5'd5, S_RX = 5'd6, S_RX_WB = 5'd7, S_BR = 5'd8, S_J = 5'd9,
    S_IX = 5'd10, S_IX_WB = 5'd11, S_LUI = 5'd12, S_JAL = 5'd13, S_JR = 5'd14,
    S_ERR = 5'd15
  } state_t;

  state_t        state_q;
  state_t        id_next;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [2:0] rx_op;
  logic [2:0] ix_op;
  logic       rx_legal;
  logic       rx_addsub;
  logic       is_addi;
  logic       trap_rx;
  logic       trap_ix;
  logic       wait_state;
  logic       timeout;
  logic       unused_ok;

  assign opcode    = Inst_in[31:26];
  assign funct     = Inst_in[5:0];
  assign is_addi   = (opcode == 6'b001000);
  assign unused_ok = &{1'b0, zero, Inst_in[25:6]};

  always_comb begin
    id_next = S_ERR;
    case (opcode)
      6'b100011, 6'b101011: id_next = S_MA;
      6'b000000:            id_next = (funct != 6'b001000) ? S_RX : (ENABLE_EXT ? S_JR : S_ERR);
      6'b000100:            id_next = S_BR;
      6'b000101:            id_next = ENABLE_EXT ? S_BR : S_ERR;
      6'b000010:            id_next = S_J;
      6'b000011:            id_next = ENABLE_EXT ? S_JAL : S_ERR;
      6'b001000, 6'b001010: id_next = S_IX;
      6'b001100, 6'b001101: id_next = ENABLE_EXT ? S_IX : S_ERR;
      6'b001111:            id_next = ENABLE_EXT ? S_LUI : S_ERR;
      default:              id_next = S_ERR;
    endcase
  end

  always_comb begin
    rx_op     = 3'b000;
    rx_legal  = 1'b1;
    rx_addsub = 1'b0;
    case (funct)
      6'b100000: begin rx_op = 3'b010; rx_addsub = 1'b1; end
      6'b100010: begin rx_op = 3'b110; rx_addsub = 1'b1; end
      6'b100100: rx_op = 3'b000;
      6'b100101: rx_op = 3'b001;
      6'b100110: begin rx_op = 3'b011; rx_legal = ENABLE_EXT; end
      6'b100111: begin rx_op = 3'b100; rx_legal = ENABLE_EXT; end
      6'b101010: rx_op = 3'b111;
      default:   rx_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (opcode)
      6'b001010: ix_op = 3'b111;
      6'b001100: ix_op = 3'b000;
      6'b001101: ix_op = 3'b001;
      default:   ix_op = 3'b010;
    endcase
  end

  assign trap_rx    = TRAP_ON_OVF && rx_addsub && overflow;
  assign trap_ix    = TRAP_ON_OVF && is_addi && overflow;
  assign wait_state = (state_q == S_IF) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timeout    = (WAIT_LIMIT != 0) && !MIO_ready && (cnt_q == LIMIT_CNT);
  assign cnt_d      = cnt_q + 1'b1;

  // The counter idles at zero outside memory states, so every entry starts clean.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      if (wait_state && !MIO_ready && !timeout) cnt_q <= cnt_d;
      else                                      cnt_q <= '0;
      case (state_q)
        S_IF:     state_q <= MIO_ready ? S_ID : (timeout ? S_ERR : S_IF);
        S_ID:     state_q <= id_next;
        S_MA:     state_q <= (opcode == 6'b101011) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD: state_q <= MIO_ready ? S_LW_WB : (timeout ? S_ERR : S_MEM_RD);
        S_MEM_WR: state_q <= MIO_ready ? S_IF : (timeout ? S_ERR : S_MEM_WR);
        S_RX:     state_q <= !rx_legal ? S_ERR : (trap_rx ? S_IF : S_RX_WB);
        S_IX:     state_q <= trap_ix ? S_IF : S_IX_WB;
        S_ERR:    state_q <= S_ERR;
        default:  state_q <= S_IF;
      endcase
    end
  end

  always_comb begin
    MemRead = 1'b0; MemWrite = 1'b0; CPU_MIO = 1'b0; IorD = 1'b0;
    IRWrite = 1'b0; RegWrite = 1'b0; ALUSrcA = 1'b0; PCWrite = 1'b0;
    PCWriteCond = 1'b0; Branch = 1'b0; RegDst = 2'b00; MemtoReg = 2'b00;
    ALUSrcB = 2'b00; PCSource = 2'b00; ALU_operation = 3'b000;
    exc_ovf = 1'b0; err = 1'b0;
    case (state_q)
      S_IF: begin
        MemRead = 1'b1; CPU_MIO = 1'b1; ALUSrcB = 2'b01; ALU_operation = 3'b010;
        IRWrite = MIO_ready; PCWrite = MIO_ready;
      end
      S_ID:     begin ALUSrcB = 2'b11; ALU_operation = 3'b010; end
      S_MA:     begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALU_operation = 3'b010; end
      S_MEM_RD: begin MemRead = 1'b1; CPU_MIO = 1'b1; IorD = 1'b1; end
      S_LW_WB:  begin MemtoReg = 2'b01; RegWrite = 1'b1; end
      S_MEM_WR: begin MemWrite = 1'b1; CPU_MIO = 1'b1; IorD = 1'b1; end
      S_RX:     begin ALUSrcA = 1'b1; ALU_operation = rx_op; exc_ovf = trap_rx; end
      S_RX_WB:  begin RegDst = 2'b01; RegWrite = 1'b1; end
      S_BR: begin
        ALUSrcA = 1'b1; ALU_operation = 3'b110; PCSource = 2'b01;
        PCWriteCond = 1'b1; Branch = (opcode == 6'b000100);
      end
      S_J:      begin PCSource = 2'b10; PCWrite = 1'b1; end
      S_IX: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALU_operation = ix_op; exc_ovf = trap_ix;
      end
      S_IX_WB:  RegWrite = 1'b1;
      S_LUI:    begin MemtoReg = 2'b10; RegWrite = 1'b1; end
      S_JAL: begin
        RegDst = 2'b10; MemtoReg = 2'b11; RegWrite = 1'b1; PCSource = 2'b10; PCWrite = 1'b1;
      end
      S_JR:     begin PCSource = 2'b11; PCWrite = 1'b1; end
      S_ERR:    err = 1'b1;
      default:  err = 1'b0;
    endcase
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_mctrl_ws.sv
// Scoreboard bench for mctrl_ws: instance 0 has WAIT_LIMIT=4 with trap and
// extended ops, instance 1 has WAIT_LIMIT=15 with both disabled.
module tb_mctrl_ws;

  typedef struct {
    int          d;
    logic [4:0]  st;
    logic [22:0] ctl;
    logic [22:0] mask;
    int          step;
  } exp_t;

  logic clk;
  logic reset;
  logic [31:0] inst;
  logic zero;
  logic overflow;
  logic mio_ready;

  logic [1:0] mem_read, mem_write, cpu_mio, iord, ir_write, reg_write;
  logic [1:0] alu_src_a, pc_write, pc_write_cond, branch, exc_ovf, err;
  logic [1:0][1:0] reg_dst, memto_reg, alu_src_b, pc_source;
  logic [1:0][2:0] alu_op;
  logic [1:0][4:0] state_out;
  logic [1:0][22:0] act_ctl;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   step = 0;

  localparam logic [31:0] LW = 32'h8E530000, SW = 32'hAE530000, ADD = 32'h02538820;
  localparam logic [31:0] SUB = 32'h02538822, XOR = 32'h02538826, JAL = 32'h0C000000;
  localparam logic [31:0] JR = 32'h03E00008, BEQ = 32'h12720002, BNE = 32'h16720002;
  localparam logic [31:0] LUI = 32'h3C105555, ADDI = 32'h2230FFFF, ANDI = 32'h3230000F;
  localparam logic [31:0] JMP = 32'h08000000;

  // Control vector field order:
  // {MemRead,MemWrite,CPU_MIO,IorD,IRWrite,RegWrite,ALUSrcA,PCWrite,PCWriteCond,Branch,
  //  RegDst,MemtoReg,ALUSrcB,PCSource,ALU_operation,exc_ovf,err}
  logic [22:0] C_IFR, C_IFN, C_ID, C_MA, C_MEMRD, C_LWWB, C_MEMWR, C_RXADD, C_RXADDT;
  logic [22:0] C_RXSUB, C_RXWB, C_BR, C_J, C_JAL, C_JR, C_IXADDT, C_IXAND, C_IXWB;
  logic [22:0] C_LUI, C_ERR;

  function automatic logic [22:0] cv(input logic [9:0] f, input logic [1:0] rd,
                                      input logic [1:0] m2r, input logic [1:0] asb,
                                      input logic [1:0] pcs, input logic [2:0] op,
                                      input logic eo, input logic er);
    return {f, rd, m2r, asb, pcs, op, eo, er};
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mctrl_ws #(
      .WAIT_LIMIT ((gi == 0) ? 4 : 15),
      .TRAP_ON_OVF(gi == 0),
      .ENABLE_EXT (gi == 0)
    ) dut (
      .clk          (clk),
      .reset        (reset),
      .Inst_in      (inst),
      .zero         (zero),
      .overflow     (overflow),
      .MIO_ready    (mio_ready),
      .MemRead      (mem_read[gi]),
      .MemWrite     (mem_write[gi]),
      .CPU_MIO      (cpu_mio[gi]),
      .IorD         (iord[gi]),
      .IRWrite      (ir_write[gi]),
      .RegWrite     (reg_write[gi]),
      .ALUSrcA      (alu_src_a[gi]),
      .PCWrite      (pc_write[gi]),
      .PCWriteCond  (pc_write_cond[gi]),
      .Branch       (branch[gi]),
      .RegDst       (reg_dst[gi]),
      .MemtoReg     (memto_reg[gi]),
      .ALUSrcB      (alu_src_b[gi]),
      .PCSource     (pc_source[gi]),
      .ALU_operation(alu_op[gi]),
      .state_out    (state_out[gi]),
      .exc_ovf      (exc_ovf[gi]),
      .err          (err[gi])
    );
    assign act_ctl[gi] = {mem_read[gi], mem_write[gi], cpu_mio[gi], iord[gi], ir_write[gi],
                          reg_write[gi], alu_src_a[gi], pc_write[gi], pc_write_cond[gi],
                          branch[gi], reg_dst[gi], memto_reg[gi], alu_src_b[gi],
                          pc_source[gi], alu_op[gi], exc_ovf[gi], err[gi]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      $display("step %0d dut%0d state=%0d ctl=%h", e.step, e.d, state_out[e.d], act_ctl[e.d]);
      checks++;
      if (state_out[e.d] !== e.st) begin
        failures++;
        $display("FAIL state step=%0d dut%0d got=%0d want=%0d", e.step, e.d, state_out[e.d], e.st);
      end
      checks++;
      if ((act_ctl[e.d] & e.mask) !== (e.ctl & e.mask)) begin
        failures++;
        $display("FAIL ctl step=%0d dut%0d got=%h want=%h mask=%h", e.step, e.d,
                 act_ctl[e.d], e.ctl, e.mask);
      end
    end
  end

  task automatic cycm(input int d, input logic [31:0] i, input logic rn, input logic rdy,
                      input logic ov, input logic [4:0] st, input logic [22:0] c,
                      input logic [22:0] m);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rn; inst = i; mio_ready = rdy; overflow = ov;
    step++;
    e.d = d; e.st = st; e.ctl = c; e.mask = m; e.step = step;
    sb.push_back(e);
  endtask

  task automatic cyc(input int d, input logic [31:0] i, input logic rdy, input logic ov,
                     input logic [4:0] st, input logic [22:0] c);
    cycm(d, i, 1'b1, rdy, ov, st, c, '1);
  endtask

  // Leaves the DUT in IF with ready high: that cycle is the next fetch.
  task automatic do_reset(input int d, input logic [31:0] i);
    cycm(d, i, 1'b0, 1'b0, 1'b0, 5'd0, C_IFN, '1);
    cycm(d, i, 1'b0, 1'b1, 1'b0, 5'd0, C_IFR, '1);
    cycm(d, i, 1'b1, 1'b1, 1'b0, 5'd0, C_IFR, '1);
  endtask

  initial begin
    reset = 1'b0; inst = '0; zero = 1'b0; overflow = 1'b0; mio_ready = 1'b0;
    C_IFR    = cv(10'b1010100100, 2'b00, 2'b00, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0);
    C_IFN    = cv(10'b1010000000, 2'b00, 2'b00, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0);
    C_ID     = cv(10'b0000000000, 2'b00, 2'b00, 2'b11, 2'b00, 3'b010, 1'b0, 1'b0);
    C_MA     = cv(10'b0000001000, 2'b00, 2'b00, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0);
    C_MEMRD  = cv(10'b1011000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
    C_LWWB   = cv(10'b0000010000, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
    C_MEMWR  = cv(10'b0111000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
    C_RXADD  = cv(10'b0000001000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0);
    C_RXADDT = cv(10'b0000001000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, 1'b1, 1'b0);
    C_RXSUB  = cv(10'b0000001000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b110, 1'b0, 1'b0);
    C_RXWB   = cv(10'b0000010000, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
    C_BR     = cv(10'b0000001011, 2'b00, 2'b00, 2'b00, 2'b01, 3'b110, 1'b0, 1'b0);
    C_J      = cv(10'b0000000100, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 1'b0, 1'b0);
    C_JAL    = cv(10'b0000010100, 2'b10, 2'b11, 2'b00, 2'b10, 3'b000, 1'b0, 1'b0);
    C_JR     = cv(10'b0000000100, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1'b0, 1'b0);
    C_IXADDT = cv(10'b0000001000, 2'b00, 2'b00, 2'b10, 2'b00, 3'b010, 1'b1, 1'b0);
    C_IXAND  = cv(10'b0000001000, 2'b00, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0);
    C_IXWB   = cv(10'b0000010000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
    C_LUI    = cv(10'b0000010000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
    C_ERR    = cv(10'b0000000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1);

    // ---- instance 0: WAIT_LIMIT=4, trap on, extended ops on ----
    do_reset(0, LW);
    cyc(0, LW, 1, 0, 5'd1, C_ID);   cyc(0, LW, 1, 0, 5'd2, C_MA);
    cyc(0, LW, 1, 0, 5'd3, C_MEMRD); cyc(0, LW, 1, 0, 5'd4, C_LWWB);
    cyc(0, SW, 1, 0, 5'd0, C_IFR);
    cyc(0, SW, 1, 0, 5'd1, C_ID);   cyc(0, SW, 1, 0, 5'd2, C_MA);
    for (int k = 0; k < 3; k++) cyc(0, SW, 0, 0, 5'd5, C_MEMWR);
    cyc(0, SW, 1, 0, 5'd5, C_MEMWR); cyc(0, JAL, 1, 0, 5'd0, C_IFR);
    cyc(0, JAL, 1, 0, 5'd1, C_ID);  cyc(0, JAL, 1, 0, 5'd13, C_JAL);
    cyc(0, JR, 1, 0, 5'd0, C_IFR);
    cyc(0, JR, 1, 0, 5'd1, C_ID);   cyc(0, JR, 1, 0, 5'd14, C_JR);
    cyc(0, BEQ, 1, 0, 5'd0, C_IFR);
    cyc(0, BEQ, 1, 0, 5'd1, C_ID);  cyc(0, BEQ, 1, 0, 5'd8, C_BR);
    cyc(0, ADD, 1, 0, 5'd0, C_IFR);
    cyc(0, ADD, 1, 0, 5'd1, C_ID);  cyc(0, ADD, 1, 1, 5'd6, C_RXADDT);
    cyc(0, SUB, 1, 1, 5'd0, C_IFR);
    cyc(0, SUB, 1, 0, 5'd1, C_ID);  cyc(0, SUB, 1, 0, 5'd6, C_RXSUB);
    cyc(0, SUB, 1, 0, 5'd7, C_RXWB); cyc(0, ADDI, 1, 0, 5'd0, C_IFR);
    cyc(0, ADDI, 1, 0, 5'd1, C_ID); cyc(0, ADDI, 1, 1, 5'd10, C_IXADDT);
    cyc(0, ANDI, 1, 0, 5'd0, C_IFR);
    cyc(0, ANDI, 1, 0, 5'd1, C_ID); cyc(0, ANDI, 1, 1, 5'd10, C_IXAND);
    cyc(0, ANDI, 1, 0, 5'd11, C_IXWB); cyc(0, LUI, 1, 0, 5'd0, C_IFR);
    cyc(0, LUI, 1, 0, 5'd1, C_ID);  cyc(0, LUI, 1, 0, 5'd12, C_LUI);
    cyc(0, JMP, 1, 0, 5'd0, C_IFR);
    cyc(0, JMP, 1, 0, 5'd1, C_ID);  cyc(0, JMP, 1, 0, 5'd9, C_J);
    cyc(0, LW, 1, 0, 5'd0, C_IFR);
    cyc(0, LW, 1, 0, 5'd1, C_ID);   cyc(0, LW, 1, 0, 5'd2, C_MA);
    for (int k = 0; k < 4; k++) cyc(0, LW, 0, 0, 5'd3, C_MEMRD);
    cyc(0, LW, 1, 0, 5'd3, C_MEMRD); cyc(0, LW, 1, 0, 5'd4, C_LWWB);
    cyc(0, SW, 1, 0, 5'd0, C_IFR);
    cyc(0, SW, 1, 0, 5'd1, C_ID);   cyc(0, SW, 1, 0, 5'd2, C_MA);
    cyc(0, SW, 0, 0, 5'd5, C_MEMWR); cyc(0, SW, 0, 0, 5'd5, C_MEMWR);
    cycm(0, SW, 1'b0, 1'b0, 1'b0, 5'd0, C_IFN, '1);
    cycm(0, SW, 1'b0, 1'b0, 1'b0, 5'd0, C_IFN, '1);
    cycm(0, SW, 1'b1, 1'b0, 1'b0, 5'd0, C_IFN, '1);
    for (int k = 0; k < 4; k++) cyc(0, SW, 0, 0, 5'd0, C_IFN);
    cyc(0, SW, 0, 0, 5'd15, C_ERR);
    cyc(0, SW, 1, 0, 5'd15, C_ERR);
    cyc(0, LW, 1, 1, 5'd15, C_ERR);

    // ---- instance 1: WAIT_LIMIT=15, no trap, extended ops off ----
    do_reset(1, ADD);
    cyc(1, ADD, 1, 0, 5'd1, C_ID);  cyc(1, ADD, 1, 1, 5'd6, C_RXADD);
    cyc(1, ADD, 1, 1, 5'd7, C_RXWB); cyc(1, LUI, 1, 0, 5'd0, C_IFR);
    cyc(1, LUI, 1, 0, 5'd1, C_ID);  cyc(1, LUI, 1, 0, 5'd15, C_ERR);
    cyc(1, LUI, 1, 0, 5'd15, C_ERR);
    do_reset(1, BNE);
    cyc(1, BNE, 1, 0, 5'd1, C_ID);  cyc(1, BNE, 1, 0, 5'd15, C_ERR);
    do_reset(1, JAL);
    cyc(1, JAL, 1, 0, 5'd1, C_ID);  cyc(1, JAL, 1, 0, 5'd15, C_ERR);
    do_reset(1, BEQ);
    cyc(1, BEQ, 1, 0, 5'd1, C_ID);  cyc(1, BEQ, 1, 0, 5'd8, C_BR);
    cyc(1, XOR, 1, 0, 5'd0, C_IFR);
    cyc(1, XOR, 1, 0, 5'd1, C_ID);
    cycm(1, XOR, 1'b1, 1'b1, 1'b0, 5'd6, C_RXADD, ~23'h00001C);
    cyc(1, XOR, 1, 0, 5'd15, C_ERR); cyc(1, XOR, 1, 0, 5'd15, C_ERR);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
